// File: rtl/mac_array_pkg.sv
// rtl/mac_array_pkg.sv - shared types and the saturating adder for mac_array
package mac_array_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } mac_state_t;

    // Widest accumulator the adder supports; callers zero-extend into this width.
    localparam int unsigned SAT_MAX_W = 63;
    localparam int unsigned SAT_IDX_W = 6;

    typedef struct packed {
        logic                 ovf;
        logic [SAT_MAX_W-1:0] sum;
    } sat_add_t;

    // Exact (width+1)-bit add of two width-bit values, wrapping or clamping on overflow.
    function automatic sat_add_t sat_add(
        input logic [SAT_MAX_W-1:0] acc,
        input logic [SAT_MAX_W-1:0] addend,
        input int unsigned          width,
        input logic                 is_signed,
        input logic                 saturate
    );
        logic [SAT_MAX_W-1:0] mask;
        logic [SAT_MAX_W:0]   a_x;
        logic [SAT_MAX_W:0]   b_x;
        logic [SAT_MAX_W:0]   full;
        sat_add_t             r;
        mask = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - width);
        a_x  = {1'b0, acc & mask};
        b_x  = {1'b0, addend & mask};
        if (is_signed) begin
            if (acc[SAT_IDX_W'(width - 1)])    a_x = a_x | {1'b1, ~mask};
            if (addend[SAT_IDX_W'(width - 1)]) b_x = b_x | {1'b1, ~mask};
        end
        full = a_x + b_x;
        if (is_signed) r.ovf = full[SAT_IDX_W'(width)] ^ full[SAT_IDX_W'(width - 1)];
        else           r.ovf = full[SAT_IDX_W'(width)];
        r.sum = full[SAT_MAX_W-1:0] & mask;
        if (r.ovf && saturate) begin
            if (!is_signed)                 r.sum = mask;
            else if (full[SAT_IDX_W'(width)]) r.sum = mask ^ (mask >> 1);
            else                            r.sum = mask >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one lane: product register, accumulator, saturation and sticky overflow
module mac_lane
    import mac_array_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  beat_i,
    input  logic                  mul_signed_i,
    input  logic                  acc_signed_i,
    input  logic                  consume_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [ACC_WIDTH-1:0]  acc_o,
    output logic                  ovf_o
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [PW-1:0]        a_ext;
    logic [PW-1:0]        b_ext;
    logic [PW-1:0]        prod_d;
    logic [PW-1:0]        prod_q;
    logic                 prod_vld_q;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] acc_d;
    logic [ACC_WIDTH-1:0] acc_q;
    logic                 ovf_d;
    logic                 ovf_q;
    sat_add_t             add_res;

    // Low PW bits of the extended product are correct for both signed and unsigned operands.
    assign a_ext  = mul_signed_i ? {{DATA_WIDTH{a_i[DATA_WIDTH-1]}}, a_i} : {{DATA_WIDTH{1'b0}}, a_i};
    assign b_ext  = mul_signed_i ? {{DATA_WIDTH{b_i[DATA_WIDTH-1]}}, b_i} : {{DATA_WIDTH{1'b0}}, b_i};
    assign prod_d = a_ext * b_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
        end else if (clr_i) begin
            prod_vld_q <= 1'b0;
        end else begin
            prod_vld_q <= beat_i;
            if (beat_i) prod_q <= prod_d;
        end
    end

    generate
        if (ACC_WIDTH > PW) begin : g_ext
            assign prod_ext = {{(ACC_WIDTH-PW){acc_signed_i & prod_q[PW-1]}}, prod_q};
        end else begin : g_noext
            assign prod_ext = prod_q;
        end
        if (ACC_WIDTH < SAT_MAX_W) begin : g_hi
            logic unused_sum_hi;
            assign unused_sum_hi = ^add_res.sum[SAT_MAX_W-1:ACC_WIDTH];
        end
    endgenerate

    assign add_res = sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(prod_ext), ACC_WIDTH,
                             acc_signed_i, SATURATE != 0);

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr_i || consume_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (prod_vld_q) begin
            acc_d = add_res.sum[ACC_WIDTH-1:0];
            ovf_d = ovf_q | add_res.ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/mac_array.sv
// rtl/mac_array.sv - broadcast-A multi-lane dot-product engine with valid/ready result handshake
module mac_array
    import mac_array_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LANES  = 4,
    parameter int VEC_LEN    = 8,
    parameter int ACC_WIDTH  = DATA_WIDTH * 3,
    parameter int SATURATE   = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            Clr,
    input  logic                            sgn,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           Ain,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] Bin,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_LANES*ACC_WIDTH-1:0]  Cout,
    output logic [NUM_LANES-1:0]            ovf
);

    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    mac_state_t       state_q;
    mac_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             mode_q;
    logic             mode_d;
    logic             beat;
    logic             first_beat;
    logic             last_beat;
    logic             consume;
    logic             mul_signed;

    assign in_ready   = (state_q == ST_ACCUM) && !Clr;
    assign out_valid  = (state_q == ST_DONE);
    assign beat       = in_valid && in_ready;
    assign first_beat = (cnt_q == '0);
    assign last_beat  = (cnt_q == CNT_W'(VEC_LEN - 1));
    // The first beat's product must already use the mode being latched on that beat.
    assign mul_signed = first_beat ? sgn : mode_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        consume = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                if (beat) begin
                    if (first_beat) mode_d = sgn;
                    if (last_beat) state_d = ST_DRAIN;
                    else           cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    consume = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
        if (Clr) begin
            state_d = ST_ACCUM;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            mac_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH),
                .SATURATE   (SATURATE)
            ) u_lane (
                .clk          (clk),
                .rst_n        (rst_n),
                .clr_i        (Clr),
                .beat_i       (beat),
                .mul_signed_i (mul_signed),
                .acc_signed_i (mode_q),
                .consume_i    (consume),
                .a_i          (Ain),
                .b_i          (Bin[i*DATA_WIDTH +: DATA_WIDTH]),
                .acc_o        (Cout[i*ACC_WIDTH +: ACC_WIDTH]),
                .ovf_o        (ovf[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_mac_array.sv
// tb/tb_mac_array.sv - directed self-checking bench for mac_array
module tb_mac_array;

    localparam int DW = 8;
    localparam int NL = 4;
    localparam int VL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic sgn = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [DW-1:0]    ain = '0;
    logic [NL*DW-1:0] bin = '0;

    logic             in_ready, out_valid;
    logic [NL*24-1:0] cout;
    logic [NL-1:0]    ovf;
    logic             s_in_ready, s_out_valid;
    logic [NL*16-1:0] s_cout;
    logic [NL-1:0]    s_ovf;
    logic             w_in_ready, w_out_valid;
    logic [NL*16-1:0] w_cout;
    logic [NL-1:0]    w_ovf;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac_array #(.DATA_WIDTH(DW), .NUM_LANES(NL), .VEC_LEN(VL), .ACC_WIDTH(24), .SATURATE(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .Clr(clr), .sgn(sgn), .in_valid(in_valid), .in_ready(in_ready),
        .Ain(ain), .Bin(bin), .out_valid(out_valid), .out_ready(out_ready), .Cout(cout), .ovf(ovf));

    mac_array #(.DATA_WIDTH(DW), .NUM_LANES(NL), .VEC_LEN(VL), .ACC_WIDTH(16), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .Clr(clr), .sgn(sgn), .in_valid(in_valid), .in_ready(s_in_ready),
        .Ain(ain), .Bin(bin), .out_valid(s_out_valid), .out_ready(out_ready), .Cout(s_cout), .ovf(s_ovf));

    mac_array #(.DATA_WIDTH(DW), .NUM_LANES(NL), .VEC_LEN(VL), .ACC_WIDTH(16), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .Clr(clr), .sgn(sgn), .in_valid(in_valid), .in_ready(w_in_ready),
        .Ain(ain), .Bin(bin), .out_valid(w_out_valid), .out_ready(out_ready), .Cout(w_cout), .ovf(w_ovf));

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] a, input logic [NL*DW-1:0] b, input logic s);
        ain      = a;
        bin      = b;
        sgn      = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        check_eq({tag, "_drain_valid"}, 128'(out_valid), 128'(0));
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 8);
        check_eq({tag, "_latency"}, 128'(n), 128'(1));
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_post_valid"}, 128'(out_valid), 128'(0));
        check_eq({tag, "_post_cout"}, 128'(cout), 128'(0));
        check_eq({tag, "_post_ready"}, 128'(in_ready), 128'(1));
    endtask

    task automatic run_unsigned(input string tag);
        for (int i = 0; i < VL; i++) send_beat(8'd3, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0);
        wait_result(tag);
        check_eq({tag, "_cout"}, 128'(cout), 128'({24'd48, 24'd36, 24'd24, 24'd12}));
        check_eq({tag, "_cout16"}, 128'(s_cout), 128'({16'd48, 16'd36, 16'd24, 16'd12}));
        check_eq({tag, "_ovf"}, 128'(ovf), 128'(0));
        consume(tag);
    endtask

    initial begin
        #12;
        check_eq("rst_in_ready", 128'(in_ready), 128'(1));
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_cout", 128'(cout), 128'(0));
        check_eq("rst_ovf", 128'(ovf), 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_unsigned("unsigned");

        // Signed mode latched on beat 0 only; -1 * {2,1,0,3} over 4 beats.
        send_beat(8'hFF, {8'd3, 8'd0, 8'd1, 8'd2}, 1'b1);
        for (int i = 1; i < VL; i++) send_beat(8'hFF, {8'd3, 8'd0, 8'd1, 8'd2}, 1'b0);
        wait_result("signed");
        check_eq("signed_cout", 128'(cout), 128'({24'hFFFFF4, 24'h000000, 24'hFFFFFC, 24'hFFFFF8}));
        check_eq("signed_cout16", 128'(s_cout), 128'({16'hFFF4, 16'h0000, 16'hFFFC, 16'hFFF8}));
        check_eq("signed_ovf", 128'(ovf), 128'(0));
        consume("signed");

        // 4 x 255*255 = 0x3F804.
        for (int i = 0; i < VL; i++) send_beat(8'hFF, {NL{8'hFF}}, 1'b0);
        wait_result("satwrap");
        check_eq("wide_cout", 128'(cout), 128'({NL{24'h03F804}}));
        check_eq("wide_ovf", 128'(ovf), 128'(0));
        check_eq("sat_cout", 128'(s_cout), 128'({NL{16'hFFFF}}));
        check_eq("sat_ovf", 128'(s_ovf), 128'(4'hF));
        check_eq("wrap_cout", 128'(w_cout), 128'({NL{16'hF804}}));
        check_eq("wrap_ovf", 128'(w_ovf), 128'(4'hF));
        consume("satwrap");

        // Gapped input and held-off consumer.
        for (int i = 0; i < VL; i++) begin
            send_beat(8'd2, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0);
            if (i < VL - 1) begin
                @(posedge clk);
                #1;
            end
        end
        wait_result("bp");
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_hold_cout", 128'(cout), 128'({24'd32, 24'd24, 24'd16, 24'd8}));
            check_eq("bp_hold_ready", 128'(in_ready), 128'(0));
            check_eq("bp_hold_valid", 128'(out_valid), 128'(1));
            @(posedge clk);
            #1;
        end
        consume("bp");

        // Clear after two beats, with a beat offered in the same cycle.
        send_beat(8'd5, {NL{8'd7}}, 1'b0);
        send_beat(8'd5, {NL{8'd7}}, 1'b0);
        clr = 1'b1;
        in_valid = 1'b1;
        ain = 8'd9;
        #1;
        check_eq("clr_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        check_eq("clr_cout", 128'(cout), 128'(0));
        for (int i = 0; i < VL; i++) send_beat(8'd1, {NL{8'd1}}, 1'b0);
        wait_result("clr");
        check_eq("clr_result", 128'(cout), 128'({NL{24'd4}}));
        consume("clr");

        // Asynchronous reset while in DRAIN.
        for (int i = 0; i < VL; i++) send_beat(8'd1, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_in_ready", 128'(in_ready), 128'(1));
        check_eq("arst_out_valid", 128'(out_valid), 128'(0));
        check_eq("arst_cout", 128'(cout), 128'(0));
        check_eq("arst_ovf", 128'(ovf), 128'(0));
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_unsigned("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_array.md
# mac_array

Parametrised multi-lane multiply-accumulate engine and successor to the single-lane MAC. One `Ain` operand is broadcast to `NUM_LANES` lanes, each with its own `Bin` operand, so the block computes one matrix-row × vector step per accepted beat. It accumulates a dot product of `VEC_LEN` terms per lane, then presents all lane results through a valid/ready handshake and clears itself automatically. It sits between the operand-fetch logic and the result writeback/FIFO.

## Interface
- `DATA_WIDTH`, 8: operand width.
- `NUM_LANES`, 4: parallel lanes; must be ≥1.
- `VEC_LEN`, 8: terms per dot product; must be ≥1.
- `ACC_WIDTH`, `DATA_WIDTH*3`: accumulator width; must be ≥ `2*DATA_WIDTH`.
- `SATURATE`, 0: 1 clamps on overflow; 0 wraps modulo 2^`ACC_WIDTH`.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Clr` in 1: synchronous abort/clear.
- `sgn` in 1: 1 selects signed two's-complement, 0 selects unsigned. Sampled on the first beat of each vector only.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: beat accepted when `in_valid && in_ready`.
- `Ain` in `DATA_WIDTH`: broadcast operand.
- `Bin` in `NUM_LANES*DATA_WIDTH`: lane i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `out_valid` out 1: results available.
- `out_ready` in 1: consumer accepts results.
- `Cout` out `NUM_LANES*ACC_WIDTH`: lane i at `[i*ACC_WIDTH +: ACC_WIDTH]`.
- `ovf` out `NUM_LANES`: sticky per-lane overflow for the current vector.

## Operation
- **Reset values:** state ACCUM, term count 0, accumulators 0, product registers 0, mode 0. Outputs: `Cout`=0, `ovf`=0, `out_valid`=0, `in_ready`=1.
- **States:**
  - ACCUM: `in_ready = !Clr`. On the accepted beat where count = `VEC_LEN-1`, go to DRAIN; otherwise increment count.
  - DRAIN: `in_ready`=0. Go to DONE on the next edge.
  - DONE: `out_valid`=1, `in_ready`=0. On `out_ready`, clear the accumulators, `ovf` and count, then go to ACCUM.
- **Pipeline:**
  - Stage 1 registers `Ain*Bin[i]` (2*`DATA_WIDTH` bits) plus a valid bit.
  - Stage 2 adds the registered product into the accumulator. The product is sign-extended to `ACC_WIDTH` if the mode is signed, zero-extended otherwise.
- **Mode:** latched on the accepted beat with count 0. Later changes to `sgn` are ignored until the next vector.
- **Overflow:** detected on the exact (`ACC_WIDTH+1`)-bit sum.
  - `SATURATE`=1 clamps to max/min for the current mode (unsigned min is 0).
  - `SATURATE`=0 wraps.
  - `ovf[i]` sets in either case and holds until the vector is consumed, `Clr`, or reset.
- **`Clr`:** takes priority over everything except reset. It flushes the stage-1 valid bit, zeroes the accumulators, `ovf` and count, and forces ACCUM. A beat presented in the same cycle is not accepted (`in_ready`=0).
- Gaps in `in_valid` are allowed; the accumulators hold on idle cycles.

## Timing
- A beat accepted at edge t reaches the accumulator at edge t+1.
- After the last beat is accepted at edge t, `out_valid` rises after edge t+1 (2-cycle latency). The final accumulated value is visible on `Cout` at that moment.
- `Cout` and `ovf` remain stable while `out_valid && !out_ready`.
- Consumption at edge u gives `Cout`=0, `out_valid`=0 and `in_ready`=1 after u. Maximum throughput is one vector per `VEC_LEN+2` cycles.
- Reset asserted mid-vector or in DONE returns all outputs to their reset values immediately, without waiting for a clock.

## Structure
- Package `mac_array_pkg` holds:
  - the state enum `mac_state_t` (ACCUM, DRAIN, DONE);
  - the saturating-add function, parametrised via arguments.
- Sub-module `mac_lane` holds one lane's product register, accumulator, saturation logic and `ovf`. `mac_array` generates `NUM_LANES` instances and owns the FSM, counter and mode register.

## Test plan
Defaults: `DATA_WIDTH`=8, `NUM_LANES`=4, `VEC_LEN`=4, `ACC_WIDTH`=24, unless stated otherwise.

- **Unsigned:** `sgn`=0, 4 beats of `Ain`=3, `Bin` lanes {1,2,3,4} → `Cout` = {12,24,36,48}, `ovf`=0, `out_valid` exactly 2 cycles after the last accept.
- **Signed:** `sgn`=1 on beat 0 then 0, `Ain`=8'hFF, lane0 `Bin`=2 for 4 beats → lane0 = 24'hFFFFF8 (−8). Confirms the mode is latched on beat 0.
- **Saturate vs wrap:** `ACC_WIDTH`=16, unsigned, 4×(255·255).
  - `SATURATE`=1 → 16'hFFFF, `ovf`=1.
  - `SATURATE`=0 → 16'hF804, `ovf`=1.
- **Backpressure and gaps:** `in_valid` toggled 1,0,1,0…; `out_ready` held 0 for 5 cycles → `Cout` stable and `in_ready`=0 throughout. After the handshake, the next cycle shows `Cout`=0 and `in_ready`=1.
- **`Clr` mid-vector:** `Clr` after 2 beats, with `in_valid`=1 in the same cycle → that beat is dropped. The next 4 beats of `Ain`=1, `Bin`=1 give `Cout`=4 per lane.
- **Reset mid-DRAIN:** drop `rst_n` in DRAIN → all outputs at reset values before the next edge. A following vector computes correctly.
